// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter. One-hot grant to one of NUM_REQ masters, held for a
// whole bus transaction, and released on end/error/withdraw/timeout.
// Optional BUSY watchdog: define BUS_WATCHDOG_EN to abort overlong transactions
// and pulse errorOUT. Without it errorOUT is tied low.
module bus_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned GRANT_TIMEOUT   = 16,
  parameter int unsigned WATCHDOG_CYCLES = 256
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         request,
  output logic [NUM_REQ-1:0]         granted,
  input  logic                       begin_transactionIN,
  input  logic                       end_transactionIN,
  input  logic                       errorIN,
  output logic                       bus_busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       errorOUT
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned TW = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [IW:0]   NumReqW = (IW + 1)'(NUM_REQ);
  localparam logic [TW-1:0] TMax    = TW'(GRANT_TIMEOUT - 1);

  // Elaboration-time parameter sanity checks
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (GRANT_TIMEOUT < 1) begin : g_bad_timeout
    $error("GRANT_TIMEOUT must be at least 1");
  end
  if (WATCHDOG_CYCLES < 1) begin : g_bad_watchdog
    $error("WATCHDOG_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StBusy} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] granted_q, granted_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic               busy_q, busy_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;

`ifdef BUS_WATCHDOG_EN
  localparam int unsigned WW = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WW-1:0] WMax = WW'(WATCHDOG_CYCLES - 1);
  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic          err_q, err_d;
`endif

  // Round-robin pick: rotate requests so ptr sits at bit 0, take lowest set bit
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IW-1:0]        pick_off;
  logic [IW-1:0]        pick_idx;
  logic [IW-1:0]        ptr_next;
  logic [IW:0]          pick_sum;
  logic [IW:0]          ptr_sum;
  logic                 pick_valid;

  // Select the next grantee starting from the priority pointer
  always_comb begin
    req_dbl    = {request, request};
    req_rot    = req_dbl[ptr_q +: NUM_REQ];
    pick_valid = |request;
    pick_off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) pick_off = IW'(i);
    end
    pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
    pick_idx = (pick_sum >= NumReqW) ? IW'(pick_sum - NumReqW) : pick_sum[IW-1:0];
    ptr_sum  = {1'b0, pick_idx} + (IW + 1)'(1);
    ptr_next = (ptr_sum == NumReqW) ? '0 : ptr_sum[IW-1:0];
  end

  logic owner_req;
  logic release_grant;

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    granted_d     = granted_q;
    owner_d       = owner_q;
    busy_d        = busy_q;
    ptr_d         = ptr_q;
    tcnt_d        = tcnt_q;
    release_grant = 1'b0;
    owner_req     = |(request & granted_q);
`ifdef BUS_WATCHDOG_EN
    wd_cnt_d      = wd_cnt_q;
    err_d         = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid && !errorIN) begin
          state_d   = StGrant;
          granted_d = NUM_REQ'(1) << pick_idx;
          owner_d   = pick_idx;
          busy_d    = 1'b1;
          ptr_d     = ptr_next;
          tcnt_d    = '0;
        end
      end
      StGrant: begin
        if (tcnt_q != TMax) tcnt_d = tcnt_q + TW'(1);
        // error > begin > withdraw > timeout; end strobe is ignored here
        if (errorIN) begin
          release_grant = 1'b1;
        end else if (begin_transactionIN) begin
          state_d = StBusy;
`ifdef BUS_WATCHDOG_EN
          wd_cnt_d = '0;
`endif
        end else if (!owner_req) begin
          release_grant = 1'b1;
        end else if (tcnt_q == TMax) begin
          release_grant = 1'b1;
        end
      end
      StBusy: begin
        if (errorIN || end_transactionIN) begin
          release_grant = 1'b1;
        end
`ifdef BUS_WATCHDOG_EN
        else if (wd_cnt_q == WMax) begin
          release_grant = 1'b1;
          err_d         = 1'b1;
        end
        if (wd_cnt_q != WMax) wd_cnt_d = wd_cnt_q + WW'(1);
`endif
      end
      default: release_grant = 1'b1;
    endcase
    if (release_grant) begin
      state_d   = StIdle;
      granted_d = '0;
      owner_d   = '0;
      busy_d    = 1'b0;
    end
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      granted_q <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      granted_q <= granted_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      tcnt_q    <= tcnt_d;
    end
  end

`ifdef BUS_WATCHDOG_EN
  // Watchdog counter and abort pulse register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end
  assign errorOUT = err_q;
`else
  assign errorOUT = 1'b0;
`endif

  assign granted  = granted_q;
  assign owner    = owner_q;
  assign bus_busy = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: expected grantees are queued when
// requests are driven and popped when a grant appears.
module tb_bus_arbiter;

  localparam int unsigned NR = 4;
`ifdef BUS_WATCHDOG_EN
  localparam int unsigned WD = 8;
`else
  localparam int unsigned WD = 256;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [NR-1:0] request;
  logic [NR-1:0] granted;
  logic          bt, et, err_in;
  logic          bus_busy;
  logic [1:0]    owner;
  logic          errorOUT;

  int n_pass   = 0;
  int n_checks = 0;
  int exp_q[$];
  logic [NR-1:0] exp_g;
  logic [1:0]    exp_o;
  int viol;

  bus_arbiter #(
    .NUM_REQ(NR),
    .GRANT_TIMEOUT(16),
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .request(request),
    .granted(granted),
    .begin_transactionIN(bt),
    .end_transactionIN(et),
    .errorIN(err_in),
    .bus_busy(bus_busy),
    .owner(owner),
    .errorOUT(errorOUT)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pop the next expected grantee; empty queue yields an all-zero expectation
  task automatic pop_exp(output logic [NR-1:0] g, output logic [1:0] o);
    int m;
    if (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      g = NR'(1) << m;
      o = 2'(m);
    end else begin
      g = '0;
      o = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; request = '0; bt = 1'b0; et = 1'b0; err_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({granted, owner, bus_busy, errorOUT} !== '0)
      $display("FAIL reset_outputs: got g=%b o=%0d busy=%b err=%b want all 0",
               granted, owner, bus_busy, errorOUT);
    else n_pass++;
    tick();
    n_checks++;
    if ({granted, bus_busy} !== '0)
      $display("FAIL idle_no_req: got g=%b busy=%b want 0", granted, bus_busy);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    exp_q.push_back(1);
    request = 4'b0010;
    tick();
    pop_exp(exp_g, exp_o);
    n_checks++;
    if ({granted, owner, bus_busy} !== {exp_g, exp_o, 1'b1})
      $display("FAIL single_grant: got g=%b o=%0d busy=%b want g=%b o=%0d busy=1",
               granted, owner, bus_busy, exp_g, exp_o);
    else n_pass++;
    // end strobe in GRANT must be ignored
    et = 1'b1;
    tick();
    et = 1'b0;
    n_checks++;
    if (granted !== 4'b0010)
      $display("FAIL grant_ignores_end: got %b want 0010", granted);
    else n_pass++;
    bt = 1'b1;
    tick();
    bt = 1'b0;
    request = '0;
    tick();
    n_checks++;
    if (granted !== 4'b0010 || bus_busy !== 1'b1)
      $display("FAIL busy_hold: got g=%b busy=%b want 0010/1", granted, bus_busy);
    else n_pass++;
    tick();
    et = 1'b1;
    tick();
    et = 1'b0;
    n_checks++;
    if ({granted, owner, bus_busy} !== '0)
      $display("FAIL single_release: got g=%b o=%0d busy=%b want 0", granted, owner, bus_busy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    request = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      pop_exp(exp_g, exp_o);
      n_checks++;
      if (granted !== exp_g || owner !== exp_o)
        $display("FAIL rr_grant%0d: got g=%b o=%0d want g=%b o=%0d",
                 k, granted, owner, exp_g, exp_o);
      else n_pass++;
      bt = 1'b1;
      tick();
      bt = 1'b0;
      et = 1'b1;
      tick();
      et = 1'b0;
      n_checks++;
      if (granted !== '0 || bus_busy !== 1'b0)
        $display("FAIL rr_dead%0d: got g=%b busy=%b want 0", k, granted, bus_busy);
      else n_pass++;
      if (k < 4) tick();
    end
    request = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    exp_q.push_back(2);
    request = 4'b0100;
    tick();
    pop_exp(exp_g, exp_o);
    n_checks++;
    if (granted !== exp_g || owner !== exp_o)
      $display("FAIL to_grant: got g=%b o=%0d want g=%b o=%0d", granted, owner, exp_g, exp_o);
    else n_pass++;
    request = 4'b0101;
    exp_q.push_back(0);
    viol = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (granted !== 4'b0100) viol++;
    end
    n_checks++;
    if (viol != 0) $display("FAIL to_hold: got %0d bad cycles want 0", viol);
    else n_pass++;
    tick();
    n_checks++;
    if (granted !== '0 || bus_busy !== 1'b0)
      $display("FAIL to_revoke: got g=%b busy=%b want 0", granted, bus_busy);
    else n_pass++;
    tick();
    pop_exp(exp_g, exp_o);
    n_checks++;
    if (granted !== exp_g || owner !== exp_o)
      $display("FAIL to_next_grant: got g=%b o=%0d want g=%b o=%0d",
               granted, owner, exp_g, exp_o);
    else n_pass++;
    request = '0;
  endtask

  task automatic test_error();
    do_reset();
    exp_q.push_back(3);
    request = 4'b1000;
    tick();
    pop_exp(exp_g, exp_o);
    n_checks++;
    if (granted !== exp_g || owner !== exp_o)
      $display("FAIL err_grant: got g=%b o=%0d want g=%b o=%0d", granted, owner, exp_g, exp_o);
    else n_pass++;
    bt = 1'b1;
    tick();
    bt = 1'b0;
    err_in = 1'b1;
    et = 1'b1;
    exp_q.push_back(3);
    tick();
    err_in = 1'b0;
    et = 1'b0;
    n_checks++;
    if (granted !== '0 || bus_busy !== 1'b0 || errorOUT !== 1'b0)
      $display("FAIL err_busy_release: got g=%b busy=%b err=%b want 0",
               granted, bus_busy, errorOUT);
    else n_pass++;
    tick();
    pop_exp(exp_g, exp_o);
    n_checks++;
    if (granted !== exp_g || owner !== exp_o)
      $display("FAIL err_regrant: got g=%b o=%0d want g=%b o=%0d",
               granted, owner, exp_g, exp_o);
    else n_pass++;
    err_in = 1'b1;
    bt = 1'b1;
    tick();
    err_in = 1'b0;
    bt = 1'b0;
    request = '0;
    n_checks++;
    if (granted !== '0 || bus_busy !== 1'b0)
      $display("FAIL err_over_begin: got g=%b busy=%b want 0", granted, bus_busy);
    else n_pass++;
    tick();
    n_checks++;
    if (granted !== '0)
      $display("FAIL err_no_busy: got g=%b want 0", granted);
    else n_pass++;
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    exp_q.push_back(2);
    request = 4'b0100;
    tick();
    pop_exp(exp_g, exp_o);
    bt = 1'b1;
    tick();
    bt = 1'b0;
    request = '0;
    n_checks++;
    if (granted !== exp_g || owner !== exp_o)
      $display("FAIL mid_busy_pre: got g=%b o=%0d want g=%b o=%0d",
               granted, owner, exp_g, exp_o);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({granted, owner, bus_busy} !== '0)
      $display("FAIL async_reset: got g=%b o=%0d busy=%b want 0", granted, owner, bus_busy);
    else n_pass++;
    #1;
    reset = 1'b0;
    request = 4'b1001;
    exp_q.push_back(0);
    tick();
    pop_exp(exp_g, exp_o);
    n_checks++;
    if (granted !== exp_g || owner !== exp_o)
      $display("FAIL post_reset_grant: got g=%b o=%0d want g=%b o=%0d",
               granted, owner, exp_g, exp_o);
    else n_pass++;
    request = '0;
  endtask

  task automatic test_watchdog();
    do_reset();
    exp_q.push_back(1);
    request = 4'b0010;
    tick();
    pop_exp(exp_g, exp_o);
    bt = 1'b1;
    tick();
    bt = 1'b0;
    request = '0;
    viol = 0;
`ifdef BUS_WATCHDOG_EN
    for (int k = 0; k < 7; k++) begin
      tick();
      if (granted !== exp_g || errorOUT !== 1'b0) viol++;
    end
    n_checks++;
    if (viol != 0) $display("FAIL wd_hold: got %0d bad cycles want 0", viol);
    else n_pass++;
    tick();
    n_checks++;
    if (errorOUT !== 1'b1 || granted !== '0)
      $display("FAIL wd_abort: got err=%b g=%b want err=1 g=0", errorOUT, granted);
    else n_pass++;
    tick();
    n_checks++;
    if (errorOUT !== 1'b0)
      $display("FAIL wd_pulse_len: got err=%b want 0", errorOUT);
    else n_pass++;
`else
    for (int k = 0; k < 100; k++) begin
      tick();
      if (granted !== exp_g || errorOUT !== 1'b0) viol++;
    end
    n_checks++;
    if (viol != 0) $display("FAIL long_busy_hold: got %0d bad cycles want 0", viol);
    else n_pass++;
    et = 1'b1;
    tick();
    et = 1'b0;
    n_checks++;
    if (granted !== '0 || errorOUT !== 1'b0)
      $display("FAIL long_busy_release: got g=%b err=%b want 0", granted, errorOUT);
    else n_pass++;
`endif
  endtask

  initial begin
    reset = 1'b1; request = '0; bt = 1'b0; et = 1'b0; err_in = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_error();
    test_reset_mid_busy();
    test_watchdog();
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter sharing the single system bus between NUM_REQ bus masters, e.g. DMA engines and CPU bridges.
- Each master exposes request/granted; the arbiter holds one grant for the whole transaction.
- The arbiter watches the shared bus begin/end/error strobes to decide when to release the grant.
- Sits between the masters' request/granted pins and the shared bus wires.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- GRANT_TIMEOUT, 16: cycles a granted master may take before asserting begin_transactionIN; expiry revokes the grant.
- WATCHDOG_CYCLES, 256: maximum BUSY length (optional feature only).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- request  in  NUM_REQ  per-master bus request, level, held until granted.
- granted  out  NUM_REQ  registered one-hot grant.
- begin_transactionIN  in  1  shared bus begin strobe.
- end_transactionIN  in  1  shared bus end strobe.
- errorIN  in  1  shared bus error.
- bus_busy  out  1  high while in GRANT or BUSY.
- owner  out  clog2(NUM_REQ)  index of the current grantee; 0 when idle.
- errorOUT  out  1  watchdog abort pulse; tied 0 without the optional feature.

Behaviour:
- Reset (async, immediate) clears: granted=0, bus_busy=0, owner=0, errorOUT=0, state=IDLE, priority pointer ptr=0, timeout counter=0.
- States: IDLE, GRANT, BUSY. All outputs are registered.
- IDLE:
  - If request!=0, pick the first set bit scanning ptr, ptr+1, … wrapping mod NUM_REQ.
  - Next edge: granted[w]=1, owner=w, bus_busy=1, ptr=(w+1) mod NUM_REQ, state=GRANT.
  - Latency is exactly one cycle from request to grant.
- GRANT:
  - begin_transactionIN=1 → BUSY; the grant is held.
  - request[owner]=0 before begin → withdraw: next edge granted=0, IDLE.
  - Counter reaches GRANT_TIMEOUT-1 with no begin → revoke: granted=0, IDLE. ptr is already past the owner, so the owner loses its turn.
  - end_transactionIN is ignored in GRANT.
- BUSY:
  - The grant is held regardless of request.
  - end_transactionIN=1 → next edge granted=0, bus_busy=0, IDLE.
- After any release there is one mandatory dead cycle in IDLE with granted=0. A new grant is visible no earlier than 2 cycles after the end strobe.
- errorIN=1 in any state → next edge granted=0, IDLE. errorIN has priority over begin/end in the same cycle.
- begin and end in the same GRANT cycle → BUSY only; the end is ignored.
- Strobes arriving in IDLE are ignored.
- owner returns to 0 whenever the arbiter enters IDLE.
- granted is never multi-hot. granted!=0 iff bus_busy=1.
- The timeout counter saturates and clears on every entry to GRANT.

Optional Feature:
- Macro: BUS_WATCHDOG_EN.
- Defined:
  - A BUSY-cycle counter clears on entry to BUSY.
  - If it reaches WATCHDOG_CYCLES-1 without end_transactionIN, errorOUT pulses high for 1 cycle on the next edge, granted=0, IDLE.
  - An end strobe in the same cycle as expiry wins: normal release, no errorOUT.
- Not defined: no counter logic; errorOUT constant 0; a BUSY transaction may last indefinitely.

Test Plan:
- Reset, then request=4'b0010 → one cycle later granted=4'b0010, owner=1, bus_busy=1. Begin pulse, end pulse 3 cycles later → granted=0 on the next edge.
- request=4'b1111 held, each grantee completes begin/end → grant order 0,1,2,3,0 with one idle cycle between grants.
- Grant master 2, no begin for 16 cycles → granted=0 on cycle 16. With request=4'b0101 still held, the next grant goes to master 0 (ptr=3 wraps).
- Grant master 3, errorIN with end_transactionIN in the same cycle, during BUSY → granted=0 next edge; during GRANT, errorIN wins over begin and no BUSY is entered.
- Assert reset mid-BUSY → granted=0 and owner=0 immediately (before the clock edge). After reset, request=4'b1001 → master 0 granted.
- With BUS_WATCHDOG_EN, WATCHDOG_CYCLES=8: begin, no end → errorOUT=1 for one cycle on BUSY cycle 8, granted=0. Without the macro, the grant is held for 100 cycles and errorOUT stays 0.
